// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array and its result drain.
// Holds the drain FSM state type, the default lane count and accumulator
// width used by both blocks, and the lane-index width helper.
package mac_pkg;

    localparam int D_W_ACC_DEF = 16;
    localparam int N_DEF       = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    // Width of a lane index; a single lane still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_result_drain.sv
// Result drain for the MAC array.
// Snapshots all N accumulator results on a capture strobe into a shadow bank
// (freeing the array immediately) and streams them out one word per
// valid/ready handshake, tagged with the lane index and a last marker.
// A capture arriving while the drain cannot take it is dropped and recorded
// in a sticky overrun flag.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   result[N]       accumulator outputs, sampled when capture is accepted
//   capture         one-cycle snapshot strobe
//   capture_ready   a capture this cycle will be accepted
//   out_data/idx    current result word and its lane index
//   out_valid       word presented; held until out_ready
//   out_ready       consumer accepts the word
//   out_last        word is lane N-1
//   overrun         sticky: a capture was dropped
//
// state | meaning
// IDLE  | shadow bank empty, waiting for a capture
// DRAIN | presenting shadow[idx] to the consumer
module mac_result_drain
    import mac_pkg::*;
#(
    parameter  int D_W_ACC = D_W_ACC_DEF,
    parameter  int N       = N_DEF,
    localparam int IDX_W   = idx_w(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_W_ACC-1:0] result [N-1:0],
    input  logic               capture,
    output logic               capture_ready,
    output logic [D_W_ACC-1:0] out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    drain_state_t       state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [D_W_ACC-1:0] shadow_q [N-1:0];
    logic [D_W_ACC-1:0] shadow_d [N-1:0];
    logic               overrun_q, overrun_d;

    logic is_last;
    logic handshake;
    logic accept;

    always_comb begin
        is_last       = (idx_q == LAST_IDX);
        out_valid     = (state_q == DRAIN);
        out_last      = out_valid & is_last;
        handshake     = out_valid & out_ready;
        // While draining, a new snapshot fits only as the last word leaves.
        capture_ready = (state_q == IDLE) | (handshake & is_last);
        accept        = capture & capture_ready;

        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        overrun_d = overrun_q;

        if (accept) begin
            state_d  = DRAIN;
            idx_d    = '0;
            shadow_d = result;
        end else if (handshake) begin
            if (is_last) begin
                state_d = IDLE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (capture & ~capture_ready) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            shadow_q  <= shadow_d;
        end
    end

    generate
        if (N == 1) begin : g_single
            assign out_data = shadow_q[0];
        end else begin : g_multi
            assign out_data = shadow_q[idx_q];
        end
    endgenerate

    assign out_idx = idx_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_mac_result_drain.sv
module tb_mac_result_drain;

    localparam int DW = 16;
    localparam int NL = 3;

    typedef struct {
        logic [DW-1:0] data;
        int            idx;
        bit            last;
    } word_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] result [NL-1:0];
    logic          capture = 1'b0;
    logic          capture_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_idx;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          overrun;

    logic [DW-1:0] result1 [0:0];
    logic          capture1 = 1'b0;
    logic          capture_ready1;
    logic [DW-1:0] out_data1;
    logic [0:0]    out_idx1;
    logic          out_valid1;
    logic          out_ready1 = 1'b0;
    logic          out_last1;
    logic          overrun1;

    int checks = 0;
    int errors = 0;

    // Reference model: words still owed to the consumer, in order.
    word_t exp_q[$];
    int    model_rem   = 0;
    bit    exp_overrun = 1'b0;

    always #5 clk = ~clk;

    mac_result_drain #(.D_W_ACC(DW), .N(NL)) dut (
        .clk(clk), .rst(rst), .result(result), .capture(capture),
        .capture_ready(capture_ready), .out_data(out_data), .out_idx(out_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .overrun(overrun)
    );

    mac_result_drain #(.D_W_ACC(DW), .N(1)) dut1 (
        .clk(clk), .rst(rst), .result(result1), .capture(capture1),
        .capture_ready(capture_ready1), .out_data(out_data1), .out_idx(out_idx1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1),
        .overrun(overrun1)
    );

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus: apply inputs, predict what the cycle does, then
    // advance past the clock edge and commit the prediction.
    task automatic step(input bit do_rst, input bit cap, input bit rdy,
                        input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                        input logic [DW-1:0] v2);
        int  rem_after;
        bit  ovr;
        rst       = do_rst;
        capture   = cap;
        out_ready = rdy;
        result[0] = v0;
        result[1] = v1;
        result[2] = v2;
        ovr       = 1'b0;
        if (do_rst) begin
            exp_q.delete();
            rem_after = 0;
        end else begin
            rem_after = model_rem - ((model_rem > 0 && rdy) ? 1 : 0);
            if (cap) begin
                if (rem_after == 0) begin
                    exp_q.push_back('{data: v0, idx: 0, last: 1'b0});
                    exp_q.push_back('{data: v1, idx: 1, last: 1'b0});
                    exp_q.push_back('{data: v2, idx: 2, last: 1'b1});
                    rem_after = NL;
                end else begin
                    ovr = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        model_rem = rem_after;
        if (do_rst) exp_overrun = 1'b0;
        else if (ovr) exp_overrun = 1'b1;
    endtask

    // Monitor: compares the presented word against the head of the expected
    // queue and pops it on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", out_valid, model_rem > 0);
            chk("overrun", overrun, exp_overrun);
            chk("capture_ready", capture_ready,
                (model_rem == 0) || (model_rem == 1 && out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got data 0x%0h idx %0d, expected none", out_data, out_idx);
                end else begin
                    chk("out_data", out_data, exp_q[0].data);
                    chk("out_idx", out_idx, exp_q[0].idx);
                    chk("out_last", out_last, exp_q[0].last);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NL; i++) result[i] = '0;
        result1[0] = '0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Reset state of the N=1 instance.
        @(negedge clk);
        chk("n1_reset_valid", out_valid1, 0);
        chk("n1_reset_data", out_data1, 0);
        chk("n1_reset_ready", capture_ready1, 1);
        @(posedge clk);
        #1;

        // Basic drain with consumer always ready.
        step(0, 1, 1, 16'h0001, 16'h0002, 16'h0003);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);

        // Stalled consumer for five cycles, then normal drain.
        step(0, 1, 0, 16'h0001, 16'h0002, 16'h0003);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);

        // Back-to-back capture on the lane-2 handshake.
        step(0, 1, 1, 16'h0001, 16'h0002, 16'h0003);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 16'hCCCC, 16'hBBBB, 16'hAAAA);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);

        // Capture while idx1 is presented is dropped and flags overrun.
        step(0, 1, 1, 16'h0011, 16'h0022, 16'h0033);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 16'h0777, 16'h0888, 16'h0999);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);

        // Reset mid-drain with a simultaneous capture.
        step(0, 1, 1, 16'h1234, 16'h5678, 16'h9ABC);
        step(0, 0, 1, 0, 0, 0);
        step(1, 1, 1, 16'h4444, 16'h5555, 16'h6666);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(3) != 0),
                 DW'($urandom), DW'($urandom), DW'($urandom));
        end
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 0);
        chk("queue_drained", exp_q.size(), 0);

        // Single-lane build.
        capture1   = 1'b1;
        out_ready1 = 1'b1;
        result1[0] = 16'hFFFF;
        @(posedge clk);
        #1;
        capture1 = 1'b0;
        @(negedge clk);
        chk("n1_valid", out_valid1, 1);
        chk("n1_data", out_data1, 16'hFFFF);
        chk("n1_idx", out_idx1, 0);
        chk("n1_last", out_last1, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("n1_idle_valid", out_valid1, 0);
        chk("n1_idle_ready", capture_ready1, 1);
        chk("n1_overrun", overrun1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
